// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Callers derive ex_is_load from the WBSel encoding (WBSel == WB_SEL_MEM).
package pipe_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    typedef enum logic [1:0] {
        WB_SEL_MEM = 2'b00,
        WB_SEL_ALU = 2'b01,
        WB_SEL_PC4 = 2'b10
    } wb_sel_t;

    localparam int DIV_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: the EX load's rd feeds a source read in ID.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic       ex_regWEn,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_valid && ex_is_load && ex_regWEn && (ex_rd != 5'd0)
                      && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: trap > redirect > divide > load-use,
// plus the multi-cycle divider sequencer and a stall performance counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regWEn,
    input  logic             ex_is_load,
    input  logic             ex_is_div,
    input  logic             ex_PCSel,
    input  logic             mem_trapReq,
    input  logic             div_done,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bubble_ex_mem,
    output logic             div_start,
    output logic             div_abort,
    output logic             div_busy,
    output logic             div_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DCNT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DIV_TIMEOUT - 1);

    div_state_t        state_reg, state_next;
    logic [DCNT_W-1:0] div_cnt_reg, div_cnt_next;
    logic              timeout_reg, timeout_next;
    logic [CNT_W-1:0]  stall_count_reg;
    logic              load_use;
    logic              redirect;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_regWEn   (ex_regWEn),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    assign redirect = ex_valid && ex_PCSel;

    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_ex_mem = 1'b0;
        div_start     = 1'b0;
        div_abort     = 1'b0;
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        timeout_next  = timeout_reg;

        if (mem_trapReq) begin
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
            if (state_reg == DIV_BUSY) begin
                div_abort    = 1'b1;
                state_next   = IDLE;
                div_cnt_next = '0;
            end
        end else if (redirect) begin
            // No stall: the PC must be free to load the branch target.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (state_reg == DIV_BUSY) begin
            if (div_done) begin
                // Release everything so EX/MEM captures the quotient this cycle.
                state_next   = IDLE;
                div_cnt_next = '0;
            end else begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                bubble_ex_mem = 1'b1;
                if (div_cnt_reg == DCNT_MAX) begin
                    timeout_next = 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + DCNT_W'(1);
                end
            end
        end else if (ex_valid && ex_is_div) begin
            div_start     = 1'b1;
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
            state_next    = DIV_BUSY;
            div_cnt_next  = '0;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            div_cnt_reg     <= '0;
            timeout_reg     <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            timeout_reg <= timeout_next;
            if (stall_pc) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
        end
    end

    assign div_busy    = (state_reg == DIV_BUSY);
    assign div_timeout = timeout_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance uses a short divide timeout.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_valid, ex_regWEn, ex_is_load, ex_is_div, ex_PCSel;
    logic       mem_trapReq, div_done;

    logic        s_pc, s_ifid, s_idex, f_ifid, f_idex, b_exmem, d_start, d_abort, d_busy, d_to;
    logic        s_pc8, s_ifid8, s_idex8, f_ifid8, f_idex8, b_exmem8, d_start8, d_abort8, d_busy8, d_to8;
    logic [31:0] stall_count, stall_count8;
    logic [9:0]  ctl, ctl8;

    int checks   = 0;
    int failures = 0;

    // ctl = {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
    //        bubble_ex_mem, div_start, div_abort, div_busy, div_timeout}
    localparam logic [9:0] C_IDLE      = 10'b000_00_0_0_0_0_0;
    localparam logic [9:0] C_LAUNCH    = 10'b111_00_1_1_0_0_0;
    localparam logic [9:0] C_BUSY      = 10'b111_00_1_0_0_1_0;
    localparam logic [9:0] C_DONE      = 10'b000_00_0_0_0_1_0;
    localparam logic [9:0] C_LU        = 10'b110_01_0_0_0_0_0;
    localparam logic [9:0] C_FLUSH     = 10'b000_11_0_0_0_0_0;
    localparam logic [9:0] C_TRAP_IDLE = 10'b000_11_1_0_0_0_0;
    localparam logic [9:0] C_TRAP_BUSY = 10'b000_11_1_0_1_1_0;

    assign ctl  = {s_pc, s_ifid, s_idex, f_ifid, f_idex, b_exmem, d_start, d_abort, d_busy, d_to};
    assign ctl8 = {s_pc8, s_ifid8, s_idex8, f_ifid8, f_idex8, b_exmem8, d_start8, d_abort8, d_busy8, d_to8};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DIV_TIMEOUT(64), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regWEn(ex_regWEn), .ex_is_load(ex_is_load),
        .ex_is_div(ex_is_div), .ex_PCSel(ex_PCSel), .mem_trapReq(mem_trapReq), .div_done(div_done),
        .stall_pc(s_pc), .stall_if_id(s_ifid), .stall_id_ex(s_idex),
        .flush_if_id(f_ifid), .flush_id_ex(f_idex), .bubble_ex_mem(b_exmem),
        .div_start(d_start), .div_abort(d_abort), .div_busy(d_busy), .div_timeout(d_to),
        .stall_count(stall_count)
    );

    pipe_hazard_ctrl #(.DIV_TIMEOUT(8), .CNT_W(32)) u_dut8 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regWEn(ex_regWEn), .ex_is_load(ex_is_load),
        .ex_is_div(ex_is_div), .ex_PCSel(ex_PCSel), .mem_trapReq(mem_trapReq), .div_done(div_done),
        .stall_pc(s_pc8), .stall_if_id(s_ifid8), .stall_id_ex(s_idex8),
        .flush_if_id(f_ifid8), .flush_id_ex(f_idex8), .bubble_ex_mem(b_exmem8),
        .div_start(d_start8), .div_abort(d_abort8), .div_busy(d_busy8), .div_timeout(d_to8),
        .stall_count(stall_count8)
    );

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_regWEn = 1'b0; ex_is_load = 1'b0;
        ex_is_div = 1'b0; ex_PCSel = 1'b0; mem_trapReq = 1'b0; div_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (ctl !== C_IDLE || ctl8 !== C_IDLE) begin
            failures++; $display("FAIL reset_ctl got=%b/%b exp=%b", ctl, ctl8, C_IDLE);
        end
        checks++;
        if (stall_count !== 32'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", stall_count);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++; $display("FAIL reset_release got=%b exp=%b", ctl, C_IDLE);
        end
        $display("test_reset done");
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_div = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LAUNCH) begin
            failures++; $display("FAIL rstdiv_launch got=%b exp=%b", ctl, C_LAUNCH);
        end
        @(negedge clk); #1;
        checks++;
        if (ctl !== C_BUSY) begin
            failures++; $display("FAIL rstdiv_busy got=%b exp=%b", ctl, C_BUSY);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE || stall_count !== 32'd0) begin
            failures++; $display("FAIL rstdiv_in_reset got=%b cnt=%0d exp=%b cnt=0", ctl, stall_count, C_IDLE);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        div_done = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++; $display("FAIL rstdiv_done_ignored got=%b exp=%b", ctl, C_IDLE);
        end
        @(negedge clk);
        div_done = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE || stall_count !== 32'd0) begin
            failures++; $display("FAIL rstdiv_after got=%b cnt=%0d exp=%b cnt=0", ctl, stall_count, C_IDLE);
        end
        $display("test_reset_mid_div done");
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_regWEn = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LU) begin
            failures++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctl !== C_IDLE || stall_count !== 32'd1) begin
            failures++; $display("FAIL lu_clear got=%b cnt=%0d exp=%b cnt=1", ctl, stall_count, C_IDLE);
        end
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_regWEn = 1'b1; ex_rd = 5'd0;
        id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_IDLE);
        end
        @(negedge clk);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; id_rs2 = 5'd1;
        #1;
        checks++;
        if (ctl !== C_LU) begin
            failures++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU);
        end
        @(negedge clk);
        id_uses_rs1 = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++; $display("FAIL lu_unused_rs1 got=%b exp=%b", ctl, C_IDLE);
        end
        @(negedge clk);
        id_uses_rs1 = 1'b1; ex_regWEn = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++; $display("FAIL lu_no_wen got=%b exp=%b", ctl, C_IDLE);
        end
        $display("test_load_use done");
    endtask

    task automatic test_div33();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_div = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LAUNCH) begin
            failures++; $display("FAIL div33_launch got=%b exp=%b", ctl, C_LAUNCH);
        end
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk); #1;
            checks++;
            if (ctl !== C_BUSY) begin
                failures++; $display("FAIL div33_busy cyc=%0d got=%b exp=%b", i, ctl, C_BUSY);
            end
        end
        @(negedge clk);
        div_done = 1'b1;
        #1;
        checks++;
        if (ctl !== C_DONE) begin
            failures++; $display("FAIL div33_done got=%b exp=%b", ctl, C_DONE);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++; $display("FAIL div33_idle got=%b exp=%b", ctl, C_IDLE);
        end
        checks++;
        if (stall_count !== 32'd34) begin
            failures++; $display("FAIL div33_count got=%0d exp=34", stall_count);
        end
        $display("test_div33 done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_div = 1'b1;
        @(negedge clk);
        @(negedge clk);
        div_done = 1'b1;
        #1;
        checks++;
        if (ctl !== C_DONE) begin
            failures++; $display("FAIL b2b_done got=%b exp=%b", ctl, C_DONE);
        end
        @(negedge clk);
        div_done = 1'b0;
        #1;
        checks++;
        if (ctl !== C_LAUNCH) begin
            failures++; $display("FAIL b2b_relaunch got=%b exp=%b", ctl, C_LAUNCH);
        end
        @(negedge clk); #1;
        checks++;
        if (ctl !== C_BUSY) begin
            failures++; $display("FAIL b2b_busy got=%b exp=%b", ctl, C_BUSY);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_trap_abort();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_div = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        mem_trapReq = 1'b1;
        #1;
        checks++;
        if (ctl !== C_TRAP_BUSY) begin
            failures++; $display("FAIL trap_abort got=%b exp=%b", ctl, C_TRAP_BUSY);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++; $display("FAIL trap_idle got=%b exp=%b", ctl, C_IDLE);
        end
        @(negedge clk);
        div_done = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            failures++; $display("FAIL trap_late_done got=%b exp=%b", ctl, C_IDLE);
        end
        checks++;
        if (stall_count !== 32'd10) begin
            failures++; $display("FAIL trap_count got=%0d exp=10", stall_count);
        end
        $display("test_trap_abort done");
    endtask

    task automatic test_redirect();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_PCSel = 1'b1; ex_is_load = 1'b1; ex_regWEn = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_FLUSH) begin
            failures++; $display("FAIL redir_lu got=%b exp=%b", ctl, C_FLUSH);
        end
        @(negedge clk);
        clear_inputs();
        ex_valid = 1'b1; ex_PCSel = 1'b1; ex_is_div = 1'b1;
        #1;
        checks++;
        if (ctl !== C_FLUSH) begin
            failures++; $display("FAIL redir_div got=%b exp=%b", ctl, C_FLUSH);
        end
        @(negedge clk);
        clear_inputs();
        ex_valid = 1'b1; ex_PCSel = 1'b1; mem_trapReq = 1'b1;
        ex_is_load = 1'b1; ex_regWEn = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (ctl !== C_TRAP_IDLE) begin
            failures++; $display("FAIL trap_idle_prio got=%b exp=%b", ctl, C_TRAP_IDLE);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctl !== C_IDLE || stall_count !== 32'd0) begin
            failures++; $display("FAIL redir_after got=%b cnt=%0d exp=%b cnt=0", ctl, stall_count, C_IDLE);
        end
        $display("test_redirect done");
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_div = 1'b1;
        #1;
        checks++;
        if (ctl8 !== C_LAUNCH) begin
            failures++; $display("FAIL to_launch got=%b exp=%b", ctl8, C_LAUNCH);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            checks++;
            if (ctl8 !== C_BUSY) begin
                failures++; $display("FAIL to_busy cyc=%0d got=%b exp=%b", i, ctl8, C_BUSY);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (ctl8 !== (C_BUSY | 10'b1)) begin
            failures++; $display("FAIL to_set got=%b exp=%b", ctl8, C_BUSY | 10'b1);
        end
        checks++;
        if (d_to !== 1'b0) begin
            failures++; $display("FAIL to_long_clear got=%b exp=0", d_to);
        end
        @(negedge clk);
        div_done = 1'b1;
        #1;
        checks++;
        if (ctl8 !== (C_DONE | 10'b1)) begin
            failures++; $display("FAIL to_done got=%b exp=%b", ctl8, C_DONE | 10'b1);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctl8 !== 10'b1) begin
            failures++; $display("FAIL to_sticky got=%b exp=%b", ctl8, 10'b1);
        end
        do_reset();
        #1;
        checks++;
        if (ctl8 !== C_IDLE) begin
            failures++; $display("FAIL to_reset got=%b exp=%b", ctl8, C_IDLE);
        end
        $display("test_timeout done");
    endtask

    initial begin
        test_reset();
        test_reset_mid_div();
        test_load_use();
        test_div33();
        test_back_to_back();
        test_trap_abort();
        test_redirect();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
